instr_fetch_unit: RTL and testbench

//   Fetch stage directly downstream of the program counter. Takes the current PC on
//   a fetch request from the control FSM and runs a req/ack read on instruction memory.

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: latches the PC on a fetch request, runs a req/ack
// read on instruction memory, captures the returned word into ir and its
// address into old_pc. Misaligned PCs and memory timeouts are reported as a
// held fault with a cause code until the next fetch request.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_IR       = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        fetch_start,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [31:0] old_pc,
    output logic        fetch_done,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    // Counter wide enough to hold TIMEOUT_CYCLES-1 with headroom; it never wraps
    // because the REQ state exits on reaching the terminal count.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_e;

    state_e           state_q,       state_d;
    logic [31:0]      addr_q,        addr_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [31:0]      ir_q,          ir_d;
    logic [31:0]      old_pc_q,      old_pc_d;
    logic [1:0]       fault_cause_q, fault_cause_d;

    // Next-state decode for the fetch FSM and its datapath registers.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        ir_d          = ir_q;
        old_pc_d      = old_pc_q;
        fault_cause_d = fault_cause_q;

        unique case (state_q)
            S_IDLE, S_FAULT: begin
                // A new request from FAULT is decoded exactly like one from IDLE.
                if (fetch_start) begin
                    if (pc[1:0] == 2'b00) begin
                        addr_d        = pc;
                        cnt_d         = '0;
                        fault_cause_d = CAUSE_NONE;
                        state_d       = S_REQ;
                    end else begin
                        fault_cause_d = CAUSE_MISALIGN;
                        state_d       = S_FAULT;
                    end
                end
            end
            S_REQ: begin
                // Ack takes priority over the timeout on the terminal cycle.
                if (mem_ack) begin
                    ir_d     = mem_rdata;
                    old_pc_d = addr_q;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_cause_d = CAUSE_TIMEOUT;
                    state_d       = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; synchronous reset overrides every update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample the pre-edge values regardless of statement order.
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            ir_q          <= RESET_IR;
            old_pc_q      <= '0;
            fault_cause_q <= CAUSE_NONE;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            ir_q          <= ir_d;
            old_pc_q      <= old_pc_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    // Handshake and status outputs decode straight from the state register.
    assign mem_req     = (state_q == S_REQ);
    assign mem_addr    = addr_q;
    assign fetch_done  = (state_q == S_DONE);
    assign busy        = (state_q == S_REQ) || (state_q == S_DONE);
    assign fault       = (state_q == S_FAULT);
    assign fault_cause = fault_cause_q;
    assign ir          = ir_q;
    assign old_pc      = old_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a short timeout. Completed fetches
// are checked against a scoreboard of expected (ir, old_pc) pairs.
module tb_instr_fetch_unit;

    localparam int unsigned TMO = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_start;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic [31:0] old_pc;
    logic        fetch_done;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_cause;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    instr_fetch_unit #(
        .TIMEOUT_CYCLES(TMO),
        .RESET_IR      (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .fetch_start(fetch_start),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ir         (ir),
        .old_pc     (old_pc),
        .fetch_done (fetch_done),
        .busy       (busy),
        .fault      (fault),
        .fault_cause(fault_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; any fetch_done pulse is matched to the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (fetch_done === 1'b1) begin
            done_cnt++;
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_ir", ir, e.ir);
                check("sb_old_pc", old_pc, e.pc);
            end
        end
    endtask

    initial begin
        int req_cycles;
        int d0;

        reset = 1'b1; pc = '0; fetch_start = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        // 1: reset state
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_ir", ir, NOP);
        check("rst_old_pc", old_pc, 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_done", 32'(fetch_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_cause", 32'(fault_cause), 32'd0);

        // 2: zero-wait fetch
        d0 = done_cnt;
        pc = 32'h10; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("zw_req", 32'(mem_req), 32'd1);
        check("zw_busy", 32'(busy), 32'd1);
        check("zw_addr", mem_addr, 32'h10);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        exp_q.push_back('{ir: 32'h0050_0093, pc: 32'h10});
        tick();
        mem_ack = 1'b0; mem_rdata = '0;
        check("zw_done", 32'(fetch_done), 32'd1);
        check("zw_req_low", 32'(mem_req), 32'd0);
        tick();
        check("zw_done_low", 32'(fetch_done), 32'd0);
        check("zw_busy_low", 32'(busy), 32'd0);
        check("zw_pulses", 32'(done_cnt - d0), 32'd1);

        // 3: wait states with pc changing mid-request
        d0 = done_cnt;
        pc = 32'h10; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0; pc = 32'h40;
        check("ws_addr_c1", mem_addr, 32'h10);
        tick();
        check("ws_req_c2", 32'(mem_req), 32'd1);
        check("ws_addr_c2", mem_addr, 32'h10);
        tick();
        check("ws_req_c3", 32'(mem_req), 32'd1);
        check("ws_addr_c3", mem_addr, 32'h10);
        mem_ack = 1'b1; mem_rdata = 32'h00A0_0113;
        exp_q.push_back('{ir: 32'h00A0_0113, pc: 32'h10});
        tick();
        mem_ack = 1'b0;
        tick(); tick();
        check("ws_pulses", 32'(done_cnt - d0), 32'd1);

        // 4: misaligned pc, then recovery
        pc = 32'h6; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("mis_fault", 32'(fault), 32'd1);
        check("mis_cause", 32'(fault_cause), 32'd1);
        check("mis_req", 32'(mem_req), 32'd0);
        tick();
        check("mis_hold_fault", 32'(fault), 32'd1);
        check("mis_hold_req", 32'(mem_req), 32'd0);
        check("mis_ir_kept", ir, 32'h00A0_0113);
        pc = 32'h8; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("rec_fault_clr", 32'(fault), 32'd0);
        check("rec_req", 32'(mem_req), 32'd1);
        check("rec_addr", mem_addr, 32'h8);
        mem_ack = 1'b1; mem_rdata = 32'h0010_0193;
        exp_q.push_back('{ir: 32'h0010_0193, pc: 32'h8});
        tick();
        mem_ack = 1'b0;
        tick();

        // 5a: timeout, never acked
        pc = 32'h20; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b1) break;
            req_cycles++;
            tick();
        end
        check("to_req_cycles", 32'(req_cycles), 32'(TMO));
        check("to_fault", 32'(fault), 32'd1);
        check("to_cause", 32'(fault_cause), 32'd2);
        check("to_ir_kept", ir, 32'h0010_0193);
        check("to_old_pc_kept", old_pc, 32'h8);

        // 5b: ack on the terminal cycle wins
        pc = 32'h24; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("ta_fault_clr", 32'(fault), 32'd0);
        tick(); tick(); tick();
        check("ta_req_c4", 32'(mem_req), 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0020_0213;
        exp_q.push_back('{ir: 32'h0020_0213, pc: 32'h24});
        tick();
        mem_ack = 1'b0;
        check("ta_done", 32'(fetch_done), 32'd1);
        check("ta_no_fault", 32'(fault), 32'd0);
        tick();

        // 6: reset during REQ with a late ack
        d0 = done_cnt;
        pc = 32'h30; fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("rr_req", 32'(mem_req), 32'd1);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("rr_req_low", 32'(mem_req), 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_ir", ir, NOP);
        check("rr_old_pc", old_pc, 32'h0);
        reset = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("rr_late_ack_ir", ir, NOP);
        check("rr_late_ack_req", 32'(mem_req), 32'd0);
        check("rr_no_done", 32'(done_cnt - d0), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("total_fetches", 32'(done_cnt), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
